acc_stack: RTL

- Parametrised, clocked accumulator for the IL pipeline. It holds the working accumulator value and adds a LIFO of saved accumulator values for nested IL parenthesised operations: "OP(" pushes, ")" pops.
- Sits between the ALU result bus and the ALU operand-A input, in place of the level-enabled 8-bit accumulator latch.
- Adds overflow/underflow detection with sticky error flags reported to the control unit.

---
 rtl/acc_stack_pkg.sv | 12 +
 rtl/acc_lifo.sv | 36 +++
 rtl/acc_stack.sv | 65 ++++++
 3 files changed

// File: rtl/acc_stack_pkg.sv
// acc_stack_pkg: default sizes and stack command encoding for acc_stack
package acc_stack_pkg;
  localparam int ACC_WIDTH = 8;
  localparam int ACC_DEPTH = 4;
  localparam int ACC_CNT_W = 3;
  typedef enum logic [1:0] {
    CMD_IDLE    = 2'b00,
    CMD_POP     = 2'b01,
    CMD_PUSH    = 2'b10,
    CMD_ILLEGAL = 2'b11
  } cmd_e;
endpackage

// File: rtl/acc_lifo.sv
// acc_lifo: LIFO storage with depth counter and full/empty decode
module acc_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             do_wr, do_rd;
  assign do_wr   = wr_i & ~rd_i & ~full_o;
  assign do_rd   = rd_i & ~wr_i & ~empty_o;
  assign full_o  = depth_q == CNT_W'(DEPTH);
  assign empty_o = depth_q == '0;
  assign depth_o = depth_q;
  assign top_o   = empty_o ? '0 : mem_q[AW'(depth_q - CNT_W'(1))];
  // next depth: count up on an accepted push, down on an accepted pop
  always_comb depth_d = do_wr ? depth_q + CNT_W'(1) : do_rd ? depth_q - CNT_W'(1) : depth_q;
  // depth counter; reset empties the stack without touching storage
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) depth_q <= '0;
    else depth_q <= depth_d;
  // storage write at the current depth (contents are don't-care after reset)
  always_ff @(posedge clk)
    if (do_wr) mem_q[AW'(depth_q)] <= din_i;
endmodule

// File: rtl/acc_stack.sv
// acc_stack: IL accumulator with a save stack for nested parenthesised operations
module acc_stack
  import acc_stack_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int DEPTH = ACC_DEPTH,
  parameter int CNT_W = ACC_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             acc_en,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] stk_top,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  output logic             op_err
);
  cmd_e             cmd;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, op_q, op_d;
  assign cmd = cmd_e'({push, pop});
  // the pre-edge accumulator is what gets saved, so "OP(" pushes old and loads new together
  acc_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lifo (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_i   (cmd == CMD_PUSH),
    .rd_i   (cmd == CMD_POP),
    .din_i  (acc_q),
    .top_o  (stk_top),
    .depth_o(depth),
    .full_o (full),
    .empty_o(empty)
  );
  // accumulator load and sticky error flags; a new event beats err_clr
  always_comb begin
    acc_d = acc_en ? acc_in : acc_q;
    ovf_d = (cmd == CMD_PUSH && full) | (ovf_q & ~err_clr);
    unf_d = (cmd == CMD_POP && empty) | (unf_q & ~err_clr);
    op_d  = (cmd == CMD_ILLEGAL) | (op_q & ~err_clr);
  end
  // state registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      op_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      op_q  <= op_d;
    end
  assign acc_out = acc_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
  assign op_err  = op_q;
endmodule
